// File: rtl/trap_seq_ctrl_pkg.sv
// Shared widths, FSM state encoding and event kinds for the trap/return sequencer.
// The optional WFI sleep state is enabled with the TRAP_SEQ_WFI_EN macro.
package trap_seq_ctrl_pkg;

  localparam int PC_WIDTH              = 32;
  localparam int EXCEPTION_CAUSE_WIDTH = 5;

  typedef enum logic [2:0] {
    TRAP_SEQ_IDLE  = 3'd0,
    TRAP_SEQ_FLUSH = 3'd1,
    TRAP_SEQ_CSR   = 3'd2,
    TRAP_SEQ_REDIR = 3'd3,
    TRAP_SEQ_WFI   = 3'd4
  } trap_state_e;

  typedef enum logic [2:0] {
    EVT_EXP  = 3'd0,
    EVT_IRQ  = 3'd1,
    EVT_MRET = 3'd2,
    EVT_SRET = 3'd3,
    EVT_WFI  = 3'd4
  } evt_kind_e;

  function automatic logic evt_is_trap(evt_kind_e kind);
    return (kind == EVT_EXP) || (kind == EVT_IRQ);
  endfunction

endpackage

// File: rtl/trap_seq_ctrl_evt_sel.sv
// trap_evt_sel: fixed-priority pick of one commit/interrupt event (exp > irq > mret > sret > wfi).
// Purely combinational; wfi only participates when TRAP_SEQ_WFI_EN is defined.
module trap_evt_sel
  import trap_seq_ctrl_pkg::*;
(
  input  logic                             cmt_valid_i,
  input  logic [PC_WIDTH-1:0]              cmt_pc_i,
  input  logic                             cmt_exp_i,
  input  logic                             cmt_mret_i,
  input  logic                             cmt_sret_i,
  input  logic                             cmt_wfi_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] cmt_ecause_i,
  input  logic [PC_WIDTH-1:0]              rob_next_pc_i,
  input  logic                             irq_pending_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] irq_cause_i,
  output logic                             evt_vld_o,
  output evt_kind_e                        evt_kind_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] evt_cause_o,
  output logic [PC_WIDTH-1:0]              evt_pc_o
);

`ifndef TRAP_SEQ_WFI_EN
  logic unused_wfi;
  assign unused_wfi = cmt_wfi_i;
`endif

  always_comb begin
    evt_vld_o   = 1'b0;
    evt_kind_o  = EVT_EXP;
    evt_cause_o = cmt_ecause_i;
    evt_pc_o    = cmt_pc_i;
    if (cmt_valid_i && cmt_exp_i) begin
      evt_vld_o = 1'b1;
    end else if (irq_pending_i) begin
      // An interrupt with no committing head resumes at the oldest unretired instruction.
      evt_vld_o   = 1'b1;
      evt_kind_o  = EVT_IRQ;
      evt_cause_o = irq_cause_i;
      evt_pc_o    = cmt_valid_i ? cmt_pc_i : rob_next_pc_i;
    end else if (cmt_valid_i && cmt_mret_i) begin
      evt_vld_o  = 1'b1;
      evt_kind_o = EVT_MRET;
    end else if (cmt_valid_i && cmt_sret_i) begin
      evt_vld_o  = 1'b1;
      evt_kind_o = EVT_SRET;
`ifdef TRAP_SEQ_WFI_EN
    end else if (cmt_valid_i && cmt_wfi_i) begin
      evt_vld_o  = 1'b1;
      evt_kind_o = EVT_WFI;
`endif
    end
  end

endmodule

// File: rtl/trap_seq_ctrl.sv
// Commit-side trap/return sequencer: IDLE -> FLUSH -> CSR -> REDIR, with a valid/ready redirect.
// The WFI sleep state exists only when TRAP_SEQ_WFI_EN is defined.
module trap_seq_ctrl
  import trap_seq_ctrl_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cmt_valid_i,
  input  logic [PC_WIDTH-1:0]              cmt_pc_i,
  input  logic                             cmt_exp_i,
  input  logic                             cmt_mret_i,
  input  logic                             cmt_sret_i,
  input  logic                             cmt_wfi_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] cmt_ecause_i,
  input  logic [PC_WIDTH-1:0]              rob_next_pc_i,
  input  logic                             irq_pending_i,
  input  logic [EXCEPTION_CAUSE_WIDTH-1:0] irq_cause_i,
  input  logic [PC_WIDTH-1:0]              csr_trap_vec_i,
  input  logic [PC_WIDTH-1:0]              csr_mepc_i,
  input  logic [PC_WIDTH-1:0]              csr_sepc_i,
  output logic                             cmt_stall_o,
  output logic                             flush_o,
  output logic                             csr_trap_we_o,
  output logic [PC_WIDTH-1:0]              csr_pc_o,
  output logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_o,
  output logic                             csr_is_irq_o,
  output logic                             csr_mret_o,
  output logic                             csr_sret_o,
  output logic                             redirect_valid_o,
  output logic [PC_WIDTH-1:0]              redirect_pc_o,
  input  logic                             redirect_ready_i,
  output logic                             wfi_o
);

  trap_state_e                      state_q, state_d;
  evt_kind_e                        kind_q, kind_d;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] cause_q, cause_d;
  logic [PC_WIDTH-1:0]              epc_q, epc_d;
  logic [PC_WIDTH-1:0]              rpc_q, redir_tgt;
  logic                             rpc_hold_q;

  logic                             sel_vld;
  evt_kind_e                        sel_kind;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] sel_cause;
  logic [PC_WIDTH-1:0]              sel_pc;

  trap_evt_sel u_evt_sel (
    .cmt_valid_i   (cmt_valid_i),
    .cmt_pc_i      (cmt_pc_i),
    .cmt_exp_i     (cmt_exp_i),
    .cmt_mret_i    (cmt_mret_i),
    .cmt_sret_i    (cmt_sret_i),
    .cmt_wfi_i     (cmt_wfi_i),
    .cmt_ecause_i  (cmt_ecause_i),
    .rob_next_pc_i (rob_next_pc_i),
    .irq_pending_i (irq_pending_i),
    .irq_cause_i   (irq_cause_i),
    .evt_vld_o     (sel_vld),
    .evt_kind_o    (sel_kind),
    .evt_cause_o   (sel_cause),
    .evt_pc_o      (sel_pc)
  );

  assign csr_pc_o     = epc_q;
  assign csr_ecause_o = cause_q;

  always_comb begin
    redir_tgt = csr_trap_vec_i;
    if (kind_q == EVT_MRET) redir_tgt = csr_mepc_i;
    if (kind_q == EVT_SRET) redir_tgt = csr_sepc_i;
  end

  // The trap vector is taken live in the first REDIR cycle (after the CSR write) and then frozen.
  assign redirect_pc_o = (state_q == TRAP_SEQ_REDIR && !rpc_hold_q) ? redir_tgt : rpc_q;

  always_comb begin
    state_d          = state_q;
    kind_d           = kind_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    cmt_stall_o      = 1'b1;
    flush_o          = 1'b0;
    csr_trap_we_o    = 1'b0;
    csr_is_irq_o     = 1'b0;
    csr_mret_o       = 1'b0;
    csr_sret_o       = 1'b0;
    redirect_valid_o = 1'b0;
    wfi_o            = 1'b0;
    case (state_q)
      TRAP_SEQ_IDLE: begin
        cmt_stall_o = irq_pending_i && !(cmt_valid_i && cmt_exp_i);
        if (sel_vld) begin
          kind_d  = sel_kind;
          cause_d = sel_cause;
          epc_d   = sel_pc;
          state_d = TRAP_SEQ_FLUSH;
        end
      end
      TRAP_SEQ_FLUSH: begin
        flush_o = 1'b1;
        state_d = TRAP_SEQ_CSR;
`ifdef TRAP_SEQ_WFI_EN
        if (kind_q == EVT_WFI) state_d = TRAP_SEQ_WFI;
`endif
      end
      TRAP_SEQ_CSR: begin
        csr_trap_we_o = evt_is_trap(kind_q);
        csr_is_irq_o  = (kind_q == EVT_IRQ);
        csr_mret_o    = (kind_q == EVT_MRET);
        csr_sret_o    = (kind_q == EVT_SRET);
        state_d       = TRAP_SEQ_REDIR;
      end
      TRAP_SEQ_REDIR: begin
        redirect_valid_o = 1'b1;
        if (redirect_ready_i) state_d = TRAP_SEQ_IDLE;
      end
`ifdef TRAP_SEQ_WFI_EN
      TRAP_SEQ_WFI: begin
        wfi_o = 1'b1;
        // Pipeline was flushed before sleeping, so wake goes straight to the CSR write.
        if (irq_pending_i) begin
          kind_d  = EVT_IRQ;
          cause_d = irq_cause_i;
          epc_d   = epc_q + PC_WIDTH'(4);
          state_d = TRAP_SEQ_CSR;
        end
      end
`endif
      default: state_d = TRAP_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TRAP_SEQ_IDLE;
      kind_q     <= EVT_EXP;
      cause_q    <= '0;
      epc_q      <= '0;
      rpc_q      <= '0;
      rpc_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      rpc_hold_q <= (state_q == TRAP_SEQ_REDIR) && !redirect_ready_i;
      if (state_q == TRAP_SEQ_REDIR && !rpc_hold_q) rpc_q <= redir_tgt;
    end
  end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Bench for trap_seq_ctrl: event-level reference model checked every cycle plus directed literal checks.
// Exercises the WFI sleep path when TRAP_SEQ_WFI_EN is defined, the NOP behaviour otherwise.
module tb_trap_seq_ctrl;
  import trap_seq_ctrl_pkg::*;

  localparam int K_EXP = 0, K_IRQ = 1, K_MRET = 2, K_SRET = 3, K_WFI = 4;
  localparam int PH_IDLE = 0, PH_FLUSH = 1, PH_CSR = 2, PH_REDIR = 3, PH_SLEEP = 4;

  logic clk, rst_n;
  logic cmt_valid_i, cmt_exp_i, cmt_mret_i, cmt_sret_i, cmt_wfi_i;
  logic [PC_WIDTH-1:0] cmt_pc_i, rob_next_pc_i, csr_trap_vec_i, csr_mepc_i, csr_sepc_i;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] cmt_ecause_i, irq_cause_i;
  logic irq_pending_i, redirect_ready_i;
  logic cmt_stall_o, flush_o, csr_trap_we_o, csr_is_irq_o, csr_mret_o, csr_sret_o;
  logic redirect_valid_o, wfi_o;
  logic [PC_WIDTH-1:0] csr_pc_o, redirect_pc_o;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_o;

  int checks = 0;
  int failures = 0;

  trap_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cmt_valid_i(cmt_valid_i), .cmt_pc_i(cmt_pc_i), .cmt_exp_i(cmt_exp_i),
    .cmt_mret_i(cmt_mret_i), .cmt_sret_i(cmt_sret_i), .cmt_wfi_i(cmt_wfi_i),
    .cmt_ecause_i(cmt_ecause_i), .rob_next_pc_i(rob_next_pc_i),
    .irq_pending_i(irq_pending_i), .irq_cause_i(irq_cause_i),
    .csr_trap_vec_i(csr_trap_vec_i), .csr_mepc_i(csr_mepc_i), .csr_sepc_i(csr_sepc_i),
    .cmt_stall_o(cmt_stall_o), .flush_o(flush_o), .csr_trap_we_o(csr_trap_we_o),
    .csr_pc_o(csr_pc_o), .csr_ecause_o(csr_ecause_o), .csr_is_irq_o(csr_is_irq_o),
    .csr_mret_o(csr_mret_o), .csr_sret_o(csr_sret_o),
    .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
    .redirect_ready_i(redirect_ready_i), .wfi_o(wfi_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkp(input string name, input logic [PC_WIDTH-1:0] act, input logic [PC_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: one in-flight event, a phase counter, and the values captured when it was taken.
  int m_phase, m_kind;
  logic [PC_WIDTH-1:0] m_epc, m_tgt;
  logic [EXCEPTION_CAUSE_WIDTH-1:0] m_cause;
  bit m_have_tgt;

  function automatic logic [PC_WIDTH-1:0] live_target();
    if (m_kind == K_MRET) return csr_mepc_i;
    if (m_kind == K_SRET) return csr_sepc_i;
    return csr_trap_vec_i;
  endfunction

  task automatic take(input int kind, input logic [EXCEPTION_CAUSE_WIDTH-1:0] cause, input logic [PC_WIDTH-1:0] pc);
    m_kind  = kind;
    m_cause = cause;
    m_epc   = pc;
    m_phase = PH_FLUSH;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_IDLE; m_kind = K_EXP; m_epc = '0; m_cause = '0; m_tgt = '0; m_have_tgt = 0;
    end else begin
      case (m_phase)
        PH_IDLE: begin
          if (cmt_valid_i && cmt_exp_i) take(K_EXP, cmt_ecause_i, cmt_pc_i);
          else if (irq_pending_i) take(K_IRQ, irq_cause_i, cmt_valid_i ? cmt_pc_i : rob_next_pc_i);
          else if (cmt_valid_i && cmt_mret_i) take(K_MRET, cmt_ecause_i, cmt_pc_i);
          else if (cmt_valid_i && cmt_sret_i) take(K_SRET, cmt_ecause_i, cmt_pc_i);
`ifdef TRAP_SEQ_WFI_EN
          else if (cmt_valid_i && cmt_wfi_i) take(K_WFI, cmt_ecause_i, cmt_pc_i);
`endif
        end
        PH_FLUSH: m_phase = (m_kind == K_WFI) ? PH_SLEEP : PH_CSR;
        PH_CSR: begin m_phase = PH_REDIR; m_have_tgt = 0; end
        PH_REDIR: begin
          if (!m_have_tgt) begin m_tgt = live_target(); m_have_tgt = 1; end
          if (redirect_ready_i) m_phase = PH_IDLE;
        end
        PH_SLEEP: if (irq_pending_i) begin
          m_kind = K_IRQ; m_cause = irq_cause_i; m_epc = m_epc + 32'd4; m_phase = PH_CSR;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    logic trap, e_we;
    trap = (m_kind == K_EXP) || (m_kind == K_IRQ);
    e_we = (m_phase == PH_CSR) && trap;
    chk1("m_stall", cmt_stall_o, (m_phase != PH_IDLE) || (irq_pending_i && !(cmt_valid_i && cmt_exp_i)));
    chk1("m_flush", flush_o, m_phase == PH_FLUSH);
    chk1("m_trap_we", csr_trap_we_o, e_we);
    chk1("m_is_irq", csr_is_irq_o, (m_phase == PH_CSR) && (m_kind == K_IRQ));
    chk1("m_mret", csr_mret_o, (m_phase == PH_CSR) && (m_kind == K_MRET));
    chk1("m_sret", csr_sret_o, (m_phase == PH_CSR) && (m_kind == K_SRET));
    chk1("m_redir_vld", redirect_valid_o, m_phase == PH_REDIR);
    chk1("m_wfi", wfi_o, m_phase == PH_SLEEP);
    if (e_we || !rst_n) begin
      chkp("m_csr_pc", csr_pc_o, m_epc);
      chkp("m_csr_cause", PC_WIDTH'(csr_ecause_o), PC_WIDTH'(m_cause));
    end
    if (m_phase == PH_REDIR) chkp("m_redir_pc", redirect_pc_o, m_have_tgt ? m_tgt : live_target());
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cmt();
    cmt_valid_i = 0; cmt_exp_i = 0; cmt_mret_i = 0; cmt_sret_i = 0; cmt_wfi_i = 0;
  endtask

  int rv_cnt, mret_cnt, wcnt;
  logic stable;
  logic [PC_WIDTH-1:0] first_pc;

  initial begin
    rst_n = 0; clear_cmt(); cmt_pc_i = '0; cmt_ecause_i = '0;
    irq_pending_i = 0; irq_cause_i = '0; redirect_ready_i = 0;
    rob_next_pc_i = 32'h8000_0040; csr_trap_vec_i = 32'h8000_0100;
    csr_mepc_i = 32'h8000_0200; csr_sepc_i = 32'h8000_0300;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_stall", cmt_stall_o, 0); chk1("rst_flush", flush_o, 0);
    chk1("rst_redir_vld", redirect_valid_o, 0); chkp("rst_redir_pc", redirect_pc_o, 0);
    chkp("rst_csr_pc", csr_pc_o, 0); chk1("rst_wfi", wfi_o, 0);
    tick(); rst_n = 1;

    // Exception with ready already high.
    tick(); cmt_valid_i = 1; cmt_exp_i = 1; cmt_ecause_i = 2; cmt_pc_i = 32'h8000_0010; redirect_ready_i = 1;
    @(negedge clk); chk1("exc_t0_stall", cmt_stall_o, 0);
    tick(); @(negedge clk); chk1("exc_t1_flush", flush_o, 1);
    tick(); @(negedge clk);
    chk1("exc_t2_we", csr_trap_we_o, 1); chkp("exc_t2_pc", csr_pc_o, 32'h8000_0010);
    chkp("exc_t2_cause", PC_WIDTH'(csr_ecause_o), 32'd2); chk1("exc_t2_irq", csr_is_irq_o, 0);
    tick(); clear_cmt(); @(negedge clk);
    chk1("exc_t3_vld", redirect_valid_o, 1); chkp("exc_t3_pc", redirect_pc_o, 32'h8000_0100);
    tick(); @(negedge clk); chk1("exc_t4_idle_vld", redirect_valid_o, 0); chk1("exc_t4_idle_stall", cmt_stall_o, 0);

    // Exception and interrupt together: exception first, interrupt on the next IDLE window.
    tick(); cmt_valid_i = 1; cmt_exp_i = 1; cmt_ecause_i = 3; cmt_pc_i = 32'h8000_0020;
    irq_pending_i = 1; irq_cause_i = 11;
    @(negedge clk); chk1("both_t0_stall", cmt_stall_o, 0);
    tick(); clear_cmt();
    tick(); @(negedge clk);
    chk1("both_t2_we", csr_trap_we_o, 1); chk1("both_t2_irq", csr_is_irq_o, 0);
    chkp("both_t2_cause", PC_WIDTH'(csr_ecause_o), 32'd3);
    tick(); tick(); @(negedge clk); chk1("irq_t4_stall", cmt_stall_o, 1);
    tick(); tick(); @(negedge clk);
    chk1("irq_t6_we", csr_trap_we_o, 1); chk1("irq_t6_is_irq", csr_is_irq_o, 1);
    chkp("irq_t6_pc", csr_pc_o, 32'h8000_0040); chkp("irq_t6_cause", PC_WIDTH'(csr_ecause_o), 32'd11);
    irq_pending_i = 0;
    tick(); tick();

    // mret with ready held low for the first four redirect cycles.
    tick(); cmt_valid_i = 1; cmt_mret_i = 1; cmt_pc_i = 32'h8000_0050; redirect_ready_i = 0;
    tick(); clear_cmt();
    rv_cnt = 0; mret_cnt = 0; stable = 1; first_pc = '0;
    repeat (10) begin
      @(negedge clk);
      if (redirect_valid_o) begin
        if (rv_cnt > 0 && redirect_pc_o !== first_pc) stable = 0;
        first_pc = redirect_pc_o;
        rv_cnt++;
      end
      if (csr_mret_o) mret_cnt++;
      tick();
      redirect_ready_i = (rv_cnt >= 4);
    end
    chki("mret_vld_cycles", rv_cnt, 5); chki("mret_pulses", mret_cnt, 1);
    chk1("mret_pc_stable", stable, 1); chkp("mret_pc", first_pc, 32'h8000_0200);

    // sret with ready high.
    tick(); cmt_valid_i = 1; cmt_sret_i = 1; cmt_pc_i = 32'h8000_0060;
    tick(); clear_cmt();
    tick(); @(negedge clk); chk1("sret_pulse", csr_sret_o, 1);
    tick(); @(negedge clk); chkp("sret_pc", redirect_pc_o, 32'h8000_0300);
    tick();

`ifdef TRAP_SEQ_WFI_EN
    tick(); cmt_valid_i = 1; cmt_wfi_i = 1; cmt_pc_i = 32'h8000_0FFC;
    tick(); clear_cmt(); @(negedge clk); chk1("wfi_t1_flush", flush_o, 1);
    wcnt = 0;
    repeat (4) begin tick(); @(negedge clk); if (wfi_o) wcnt++; end
    tick(); irq_pending_i = 1; irq_cause_i = 7; @(negedge clk); if (wfi_o) wcnt++;
    tick(); irq_pending_i = 0; @(negedge clk);
    chki("wfi_cycles", wcnt, 5); chk1("wfi_wake_we", csr_trap_we_o, 1);
    chkp("wfi_wake_pc", csr_pc_o, 32'h8000_1000); chkp("wfi_wake_cause", PC_WIDTH'(csr_ecause_o), 32'd7);
    tick(); @(negedge clk); chk1("wfi_redir_vld", redirect_valid_o, 1);
    tick();
`else
    tick(); cmt_valid_i = 1; cmt_wfi_i = 1; cmt_pc_i = 32'h8000_0FFC;
    @(negedge clk); chk1("wfi_nop_stall", cmt_stall_o, 0);
    tick(); clear_cmt(); @(negedge clk);
    chk1("wfi_nop_flush", flush_o, 0); chk1("wfi_nop_wfi", wfi_o, 0); chk1("wfi_nop_stall2", cmt_stall_o, 0);
`endif

    // Reset asserted while waiting in REDIR.
    tick(); redirect_ready_i = 0; cmt_valid_i = 1; cmt_exp_i = 1; cmt_ecause_i = 4; cmt_pc_i = 32'h8000_0070;
    tick(); clear_cmt();
    tick(); tick(); @(negedge clk); chk1("rstmid_vld_before", redirect_valid_o, 1);
    #2 rst_n = 0;
    #1;
    chk1("rstmid_vld", redirect_valid_o, 0); chk1("rstmid_stall", cmt_stall_o, 0);
    chk1("rstmid_flush", flush_o, 0); chk1("rstmid_we", csr_trap_we_o, 0);
    chkp("rstmid_csr_pc", csr_pc_o, 0); chkp("rstmid_redir_pc", redirect_pc_o, 0);
    tick(); rst_n = 1; redirect_ready_i = 1;
    repeat (3) begin
      tick(); @(negedge clk);
      chk1("post_rst_flush", flush_o, 0); chk1("post_rst_vld", redirect_valid_o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/trap_seq_ctrl.md
# trap_seq_ctrl

Sequencer for the commit-side trap/return path. Monitors the ROB commit head and the pending-interrupt level, picks one event per window, and sequences it as pipeline flush, CSR update, then fetch redirect with a valid/ready handshake. It replaces the single-cycle combinational trap signalling with a multi-cycle FSM. It sits between RCU commit, the CSR file and the fetch redirect port.

## Interface
- PC_WIDTH, from params.vh, PC width
- EXCEPTION_CAUSE_WIDTH, from params.vh, cause width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- cmt_valid_i  in  1  ROB head commits this cycle
- cmt_pc_i  in  PC_WIDTH  PC of head
- cmt_exp_i / cmt_mret_i / cmt_sret_i / cmt_wfi_i  in  1 each  head attributes
- cmt_ecause_i  in  EXCEPTION_CAUSE_WIDTH  exception cause
- rob_next_pc_i  in  PC_WIDTH  PC of oldest unretired instruction
- irq_pending_i  in  1  level, enabled interrupt pending
- irq_cause_i  in  EXCEPTION_CAUSE_WIDTH  interrupt cause
- csr_trap_vec_i / csr_mepc_i / csr_sepc_i  in  PC_WIDTH  CSR values
- cmt_stall_o  out  1  block ROB retirement
- flush_o  out  1  global pipeline flush pulse
- csr_trap_we_o  out  1  write epc/cause/status for trap
- csr_pc_o  out  PC_WIDTH  epc value
- csr_ecause_o  out  EXCEPTION_CAUSE_WIDTH  cause value
- csr_is_irq_o  out  1  cause is interrupt
- csr_mret_o / csr_sret_o  out  1 each  return status update pulse
- redirect_valid_o  out  1  redirect request to fetch
- redirect_pc_o  out  PC_WIDTH  redirect target
- redirect_ready_i  in  1  fetch accepts redirect
- wfi_o  out  1  core sleeping

## Operation
- States: IDLE, FLUSH, CSR, REDIR, WFI.
- IDLE event selection, fixed priority: exception (cmt_valid_i & cmt_exp_i) > interrupt (irq_pending_i) > mret > sret > wfi; mret/sret/wfi also require cmt_valid_i.
- cmt_stall_o = 1 in every state except IDLE. In IDLE it is 1 combinationally when irq_pending_i and no exception, so the head does not retire.
- On event: latch kind, cause (cmt_ecause_i or irq_cause_i), epc. Exception: epc = cmt_pc_i. Interrupt: epc = cmt_valid_i ? cmt_pc_i : rob_next_pc_i. Then go to FLUSH.
- FLUSH: flush_o = 1 for exactly one cycle. Next state is CSR, or WFI for wfi.
- CSR: one-cycle pulse. Trap: csr_trap_we_o with latched csr_pc_o/csr_ecause_o/csr_is_irq_o. Ret: csr_mret_o or csr_sret_o. Next state REDIR.
- REDIR: redirect_valid_o = 1 and redirect_pc_o held stable until redirect_ready_i.
  - Target for trap: csr_trap_vec_i, sampled in REDIR, i.e. after the CSR write.
  - Target for mret: csr_mepc_i. For sret: csr_sepc_i.
  - On handshake, go to IDLE.
- WFI: wfi_o = 1. Wait for irq_pending_i, then latch irq_cause_i with epc = latched wfi PC + 4 (PC_WIDTH wrap-around) and go to CSR (pipeline already flushed).
- Synchronous events arriving outside IDLE are ignored. The ROB is stalled, so the head is re-presented later.

## Timing
- Reset: state IDLE. Every output 0, except csr_pc_o/redirect_pc_o/csr_ecause_o, which are 0 (registers cleared).
- Reset mid-sequence aborts immediately with no further pulses.
- Trap latency, event to redirect_valid_o: 3 cycles (IDLE→FLUSH→CSR→REDIR).
- WFI wake: irq_pending_i seen in cycle t gives csr_trap_we_o at t+1 and redirect_valid_o at t+2.
- redirect_ready_i already high when REDIR is entered: completes in 1 cycle. Back-to-back events: next one is accepted no sooner than the cycle after returning to IDLE.

## Configuration
- TRAP_SEQ_WFI_EN defined: WFI state present as above.
- TRAP_SEQ_WFI_EN undefined:
  - cmt_wfi_i is ignored; WFI retires as a NOP with no stall or flush.
  - wfi_o is tied 0 and the WFI state is not generated.

## Structure
- params.vh holds:
  - state encoding constants (TRAP_SEQ_IDLE..TRAP_SEQ_WFI, 3 bits);
  - event kind constants (EVT_EXP, EVT_IRQ, EVT_MRET, EVT_SRET, EVT_WFI).
- One combinational sub-module, trap_evt_sel: priority encoder producing event-valid, kind, cause and epc. The FSM and latches stay in trap_seq_ctrl.

## Test plan
- Exception: cmt_valid_i=1, cmt_exp_i=1, cause=2, pc=0x8000_0010, csr_trap_vec_i=0x8000_0100, ready=1.
  - Required: flush_o at t+1; csr_trap_we_o at t+2 with pc 0x8000_0010 and cause 2; redirect 0x8000_0100 at t+3; IDLE at t+4.
- Exception and interrupt in the same cycle → exception taken, csr_is_irq_o=0. Interrupt serviced on the next IDLE window with epc=rob_next_pc_i.
- mret with csr_mepc_i=0x8000_0200, ready held low 4 cycles → redirect_valid_o high 4+1 cycles with a stable PC, csr_mret_o pulsed once.
- With WFI_EN: wfi at pc 0x8000_0FFC, irq 5 cycles later, cause 7 → wfi_o high for 5 cycles, csr_pc_o=0x8000_1000.
- rst_n dropped while in REDIR → all outputs 0 asynchronously; after release, the FSM is in IDLE with no flush or redirect.
